iencoder: RTL and testbench
===========================

IENCODER -- requirements
Module: iencoder

Interface
REQ-001 SHALL have parameter: ADDR_BITS, 10, instruction-memory word-address width.
REQ-002 SHALL import brisc_pkg (ILEN=32, OPCODE_BITS=7, REG_LEN, itype_e) and use RegBits=$clog2(REG_LEN).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle program-load request, sampled only in IDLE.
REQ-007 base_addr  in  ADDR_BITS  first word address, captured on start.
REQ-008 len  in  ADDR_BITS+1  number of valid words to emit, captured on start.
REQ-009 in_valid / in_ready  in / out  1 / 1  field-bundle handshake.
REQ-010 i_type  in  itype_e  format selector; only R, I, S and B are encodable.
REQ-011 opcode  in  7;  rs1, rs2, rd  in  RegBits;  funct7  in  7;  funct3  in  3  instruction fields.
REQ-012 i_imm  in  12;  s_imm  in  12;  b_imm  in  [12:1]  immediates.
REQ-013 out_valid / out_ready  out / in  1 / 1  memory-write handshake.
REQ-014 out_instr  out  32;  out_addr  out  ADDR_BITS  encoded word and its target address.
REQ-015 busy  out  1;  done  out  1 (one-cycle pulse);  err_count  out  8 (rejected bundles).

Function
REQ-016 SHALL implement states IDLE, RUN and DRAIN.
REQ-017 IDLE + start with len>0: capture base_addr and len, clear the word index, go to RUN.
REQ-018 IDLE + start with len==0: pulse done the next cycle and stay in IDLE.
REQ-019 in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-020 An accept (in_valid && in_ready) with a valid type SHALL register the encoded word the next cycle: out_valid=1, out_addr=(base+index) mod 2^ADDR_BITS, index+1, remaining-1.
REQ-021 R: funct7|rs2|rs1|funct3|rd|opcode.
REQ-022 I: i_imm[11:0]|rs1|funct3|rd|opcode.
REQ-023 S: s_imm[11:5]|rs2|rs1|funct3|s_imm[4:0]|opcode.
REQ-024 B: b_imm[12]|b_imm[10:5]|rs2|rs1|funct3|b_imm[4:1]|b_imm[11]|opcode.
REQ-025 An accept with any other type SHALL be consumed with no output word; err_count+1, saturating at 255; index and remaining unchanged.
REQ-026 An accept that takes remaining to 0 SHALL move the FSM to DRAIN; in_ready=0 in DRAIN.
REQ-027 While out_valid && !out_ready, out_instr and out_addr SHALL hold stable; out_valid drops only after a handshake.
REQ-028 An output handshake and a new accept in the same cycle SHALL replace the word with no bubble (one word per cycle sustained).
REQ-029 DRAIN + output handshake: done=1 for exactly one cycle, go to IDLE.
REQ-030 The address SHALL wrap from 2^ADDR_BITS-1 to 0 silently.
REQ-031 start outside IDLE SHALL be ignored; busy = (state != IDLE).
REQ-032 Latency from accept to out_valid SHALL be 1 cycle.

Reset
REQ-033 rst SHALL take priority over every other input, including mid-RUN and mid-DRAIN; any pending word is discarded.
REQ-034 Reset values: state=IDLE, out_valid=0, out_instr=0, out_addr=0, in_ready=0, busy=0, done=0, err_count=0, index=0, remaining=0.

Verification
REQ-035 start base=0x10 len=1; R add (op 0x33, rd3, rs1 1, rs2 2, f3 0, f7 0) -> out_instr 0x002081B3 at out_addr 0x10, then done pulse.
REQ-036 len=3: I addi x5,x0,-1, S sw x2,8(x1), B beq x1,x2,-4; out_ready=1 -> 0xFFF00293, 0x0020A423, 0xFE208EE3 on consecutive cycles at base, base+1, base+2.
REQ-037 out_ready held 0 for 5 cycles with in_valid=1 -> out_instr stable, in_ready=0, no word lost or duplicated after release.
REQ-038 base=0x3FF len=2, plus one i_type=U bundle interleaved -> addresses 0x3FF then 0x000; err_count=1; exactly 2 words emitted.
REQ-039 rst asserted in RUN after 1 of 4 words -> all outputs at reset values next cycle; a new start with len=1 then completes normally.
REQ-040 start with len=0 -> done pulse 1 cycle later, in_ready stays 0, no output words.

Source files
------------

// File: rtl/iencoder.sv
// brisc_pkg: shared ISA constants and the instruction-format selector.
package brisc_pkg;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned OPCODE_BITS = 7;
  localparam int unsigned REG_LEN     = 32;
  localparam int unsigned RegBits     = $clog2(REG_LEN);

  typedef enum logic [2:0] {
    ITYPE_R = 3'd0,
    ITYPE_I = 3'd1,
    ITYPE_S = 3'd2,
    ITYPE_B = 3'd3,
    ITYPE_U = 3'd4,
    ITYPE_J = 3'd5
  } itype_e;
endpackage

// iencoder: packs R/I/S/B field bundles into 32-bit instruction words and
// streams them, with consecutive word addresses, to an instruction memory.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, base_addr, len program-load request (sampled in IDLE only)
//   in_valid/in_ready     field-bundle handshake
//   i_type..b_imm         instruction fields and immediates
//   out_valid/out_ready   memory-write handshake; out_instr at out_addr
//   busy, done, err_count status: active, one-cycle completion, rejects
module iencoder
  import brisc_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_BITS-1:0]   base_addr,
  input  logic [ADDR_BITS:0]     len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  itype_e                 i_type,
  input  logic [OPCODE_BITS-1:0] opcode,
  input  logic [RegBits-1:0]     rs1,
  input  logic [RegBits-1:0]     rs2,
  input  logic [RegBits-1:0]     rd,
  input  logic [6:0]             funct7,
  input  logic [2:0]             funct3,
  input  logic [11:0]            i_imm,
  input  logic [11:0]            s_imm,
  input  logic [12:1]            b_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ILEN-1:0]        out_instr,
  output logic [ADDR_BITS-1:0]   out_addr,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS:0]   index;
  logic [ADDR_BITS:0]   remaining;
  logic [ILEN-1:0]      enc;
  logic                 type_ok;
  logic                 accept;

  // Output slot is free when empty or being drained this cycle.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Field packing per instruction format; other formats are rejected.
  always_comb begin
    enc     = '0;
    type_ok = 1'b1;
    case (i_type)
      ITYPE_R: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      ITYPE_I: enc = {i_imm, rs1, funct3, rd, opcode};
      ITYPE_S: enc = {s_imm[11:5], rs2, rs1, funct3, s_imm[4:0], opcode};
      ITYPE_B: enc = {b_imm[12], b_imm[10:5], rs2, rs1, funct3,
                      b_imm[4:1], b_imm[11], opcode};
      default: type_ok = 1'b0;
    endcase
  end

  // Control FSM with registered output word and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      index     <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      // A handshake empties the slot unless a new accept refills it below.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              base      <= base_addr;
              remaining <= len;
              index     <= '0;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (accept) begin
            if (type_ok) begin
              out_valid <= 1'b1;
              out_instr <= enc;
              // Address wraps naturally at the ADDR_BITS boundary.
              out_addr  <= base + index[ADDR_BITS-1:0];
              index     <= index + (ADDR_BITS+1)'(1);
              remaining <= remaining - (ADDR_BITS+1)'(1);
              if (remaining == (ADDR_BITS+1)'(1)) state <= DRAIN;
            end else if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iencoder.sv
// tb_iencoder: directed stimulus for iencoder; expected words are queued on
// accept and popped by an independent monitor on each output handshake.
module tb_iencoder;
  import brisc_pkg::*;

  localparam int unsigned AB = 10;

  typedef struct {
    logic [31:0]   instr;
    logic [AB-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] base_addr;
  logic [AB:0]   len;
  logic          in_valid;
  logic          in_ready;
  itype_e        i_type;
  logic [6:0]    opcode;
  logic [4:0]    rs1, rs2, rd;
  logic [6:0]    funct7;
  logic [2:0]    funct3;
  logic [11:0]   i_imm, s_imm;
  logic [12:1]   b_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AB-1:0] out_addr;
  logic          busy;
  logic          done;
  logic [7:0]    err_count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   words    = 0;

  bit            hold = 1'b0;
  logic [31:0]   h_instr;
  logic [AB-1:0] h_addr;

  iencoder #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .i_type(i_type),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .funct7(funct7),
    .funct3(funct3), .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // Monitor: pops on handshake, tracks done pulses and stall stability.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        words++;
        check("word_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_instr", out_instr, e.instr);
          check("out_addr", 32'(out_addr), 32'(e.addr));
        end
      end
      if (hold) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_instr", out_instr, h_instr);
        check("stall_addr", 32'(out_addr), 32'(h_addr));
      end
      hold    = out_valid && !out_ready;
      h_instr = out_instr;
      h_addr  = out_addr;
    end
  end

  task automatic do_start(input logic [AB-1:0] b, input logic [AB:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one bundle and returns #1 after the edge that accepted it.
  task automatic send(input itype_e t, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [11:0] ii,
                      input logic [11:0] si, input logic [12:1] bi,
                      input bit expect_word, input logic [31:0] ei,
                      input logic [AB-1:0] ea);
    bit got;
    exp_t e;
    i_type = t; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; i_imm = ii; s_imm = si; b_imm = bi;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("send_accept", 32'(got), 32'd1);
    if (got && expect_word) begin
      e.instr = ei;
      e.addr  = ea;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
    end
    check("done_count", 32'(done_cnt), 32'(target));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int dtarget;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; in_valid = 1'b0;
    i_type = ITYPE_R; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
    funct7 = '0; funct3 = '0; i_imm = '0; s_imm = '0; b_imm = '0;
    out_ready = 1'b1;
    dtarget = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single R-type word.
    do_start(10'h010, 11'd1);
    check("busy_run", 32'(busy), 32'd1);
    send(ITYPE_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, '0, '0, '0,
         1'b1, 32'h002081B3, 10'h010);
    check("latency_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    dtarget++;
    wait_done(dtarget);
    check("busy_idle", 32'(busy), 32'd0);

    // I, S, B back to back, no bubbles.
    w0 = words;
    do_start(10'h020, 11'd3);
    send(ITYPE_I, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, '0, '0,
         1'b1, 32'hFFF00293, 10'h020);
    send(ITYPE_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, '0, 12'd8, '0,
         1'b1, 32'h0020A423, 10'h021);
    send(ITYPE_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, '0, '0, 12'hFFE,
         1'b1, 32'hFE208EE3, 10'h022);
    check("burst_throughput", 32'(words - w0), 32'd2);
    in_valid = 1'b0;
    dtarget++;
    wait_done(dtarget);
    check("burst_words", 32'(words - w0), 32'd3);

    // Backpressure: hold out_ready low with a bundle waiting.
    w0 = words;
    out_ready = 1'b0;
    do_start(10'h040, 11'd3);
    send(ITYPE_R, 7'h33, 5'd7, 5'd8, 5'd9, 3'd4, 7'h20, '0, '0, '0,
         1'b1, {7'h20, 5'd9, 5'd8, 3'd4, 5'd7, 7'h33}, 10'h040);
    fork
      begin
        send(ITYPE_I, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 12'h001, '0, '0,
             1'b1, 32'h00108093, 10'h041);
        send(ITYPE_I, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 12'h002, '0, '0,
             1'b1, 32'h00210113, 10'h042);
        in_valid = 1'b0;
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    dtarget++;
    wait_done(dtarget);
    check("stall_words", 32'(words - w0), 32'd3);

    // Zero-length load.
    w0 = words;
    do_start(10'h000, 11'd0);
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_in_ready", 32'(in_ready), 32'd0);
    check("len0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_done_drop", 32'(done), 32'd0);
    dtarget++;
    @(posedge clk); #1;
    check("len0_words", 32'(words - w0), 32'd0);

    // Reset mid-run with a pending word.
    do_start(10'h080, 11'd4);
    send(ITYPE_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 12'h003, '0, '0,
         1'b1, 32'h00300193, 10'h080);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(ITYPE_I, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 12'h004, '0, '0,
         1'b1, 32'h00400213, 10'h081);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_instr", out_instr, 32'd0);
    check("mid_rst_out_addr", 32'(out_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_start(10'h090, 11'd1);
    send(ITYPE_I, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 12'h006, '0, '0,
         1'b1, 32'h00600313, 10'h090);
    in_valid = 1'b0;
    dtarget = done_cnt + 1;
    wait_done(dtarget);

    // Address wrap with a rejected U-type bundle in between.
    w0 = words;
    do_start(10'h3FF, 11'd2);
    send(ITYPE_I, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'hFFF, '0, '0,
         1'b1, 32'hFFF00293, 10'h3FF);
    send(ITYPE_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, '0, '0, '0,
         1'b0, 32'h0, 10'h0);
    send(ITYPE_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, '0, 12'd8, '0,
         1'b1, 32'h0020A423, 10'h000);
    in_valid = 1'b0;
    dtarget++;
    wait_done(dtarget);
    check("wrap_err_count", 32'(err_count), 32'd1);
    check("wrap_words", 32'(words - w0), 32'd2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
